// File: rtl/led_sequencer.sv
// Start/stop controlled LED pattern sequencer with a prescaled step timer.
// Patterns: BLINK, CHASE, BOUNCE and COUNT, optionally ending after a fixed number of steps.
module led_sequencer #(
    parameter int NUM_LEDS = 4,
    parameter int TICK_DIV = 25000000,
    parameter int STEP_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [1:0]          mode,
    input  logic [STEP_W-1:0]   steps,
    output logic [NUM_LEDS-1:0] leds,
    output logic                busy,
    output logic                done
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {M_BLINK, M_CHASE, M_BOUNCE, M_COUNT} pattern_t;

    state_t              state_q, state_d;
    pattern_t            mode_q, mode_d;
    logic [STEP_W-1:0]   steps_q, steps_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic                dir_right_q, dir_right_d;
    logic [NUM_LEDS-1:0] leds_q, leds_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tick;
    logic [STEP_W-1:0]   step_cnt_inc;
    logic [NUM_LEDS-1:0] bounce_next;

    assign tick         = (presc_q == TICK_LAST);
    assign step_cnt_inc = step_cnt_q + STEP_W'(1);
    assign bounce_next  = dir_right_q ? (leds_q >> 1) : (leds_q << 1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        steps_d     = steps_q;
        step_cnt_d  = step_cnt_q;
        presc_d     = presc_q;
        dir_right_d = dir_right_q;
        leds_d      = leds_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        if (stop) begin
            state_d = IDLE;
            leds_d  = '0;
            busy_d  = 1'b0;
            presc_d = '0;
        end else if (start) begin
            state_d     = RUN;
            busy_d      = 1'b1;
            presc_d     = '0;
            step_cnt_d  = '0;
            dir_right_d = 1'b0;
            mode_d      = pattern_t'(mode);
            steps_d     = steps;
            case (pattern_t'(mode))
                M_BLINK: leds_d = '1;
                M_COUNT: leds_d = '0;
                default: leds_d = NUM_LEDS'(1);
            endcase
        end else if (state_q == RUN) begin
            if (!tick) begin
                presc_d = presc_q + PW'(1);
            end else begin
                presc_d    = '0;
                step_cnt_d = step_cnt_inc;
                // Completing tick shows no new pattern; it drops straight to idle.
                if (steps_q != '0 && step_cnt_inc == steps_q) begin
                    state_d = IDLE;
                    leds_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    case (mode_q)
                        M_BLINK: leds_d = ~leds_q;
                        M_CHASE: leds_d = {leds_q[NUM_LEDS-2:0], leds_q[NUM_LEDS-1]};
                        M_BOUNCE: begin
                            leds_d = bounce_next;
                            if (!dir_right_q && bounce_next[NUM_LEDS-1]) dir_right_d = 1'b1;
                            if (dir_right_q && bounce_next[0])           dir_right_d = 1'b0;
                        end
                        default: leds_d = leds_q + NUM_LEDS'(1);
                    endcase
                end
            end
        end else begin
            presc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= M_BLINK;
            steps_q     <= '0;
            step_cnt_q  <= '0;
            presc_q     <= '0;
            dir_right_q <= 1'b0;
            leds_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            steps_q     <= steps_d;
            step_cnt_q  <= step_cnt_d;
            presc_q     <= presc_d;
            dir_right_q <= dir_right_d;
            leds_q      <= leds_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign leds = leds_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
